ext_mem_arbiter: RTL and testbench
==================================

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 SHALL have parameter EXT_MEM_HEIGHT, default 256, meaning the external memory depth in words; address width is AW = $clog2(EXT_MEM_HEIGHT).
REQ-002 SHALL have parameter EXT_MEM_WIDTH, default 32, meaning the memory word width DW.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning the width of each bandwidth counter.
REQ-004 SHALL have ports, in this order (clock and reset first):
- clk  in  1  sole clock, rising edge.
- arst_n_in  in  1  reset, asynchronous, active-low.
- rd_valid  in  2  read request from client i (bit i).
- rd0_addr, rd1_addr  in  AW each  read address of client i.
- rd_ready  out  2  read grant to client i; the request is accepted when valid and ready are both high.
- rd_rsp_valid  out  2  read data valid for client i.
- rd_rsp_data  out  DW  read data, shared by both clients.
- wr_valid  in  2  write request from client i.
- wr0_addr, wr1_addr  in  AW each  write address of client i.
- wr0_data, wr1_data  in  DW each  write data of client i.
- wr_ready  out  2  write grant to client i.
- ext_mem_read_addr  out  AW  memory read address.
- ext_mem_read_en  out  1  memory read enable.
- ext_mem_qout  in  DW  memory read data, valid one cycle after read_en.
- ext_mem_write_addr  out  AW  memory write address.
- ext_mem_din  out  DW  memory write data.
- ext_mem_write_en  out  1  memory write enable.
- clear_counts  in  1  synchronous clear of both counters.
- rd_count  out  CNT_WIDTH  number of accepted reads.
- wr_count  out  CNT_WIDTH  number of accepted writes.

Function
REQ-005 SHALL arbitrate the read port and the write port independently, each between its two clients, in the same cycle.
REQ-006 Each port SHALL have a 1-bit round-robin pointer naming the preferred client.
- When both clients are valid, the preferred client is granted.
- When only one client is valid, that client is granted regardless of the pointer.
REQ-007 After a grant to client i, that port's pointer SHALL update to 1-i on the next edge. With no grant, the pointer is held.
REQ-008 Grants SHALL be combinational from the valid inputs and the registered pointer.
- ready is high only for the granted client and is never high for both clients of one port.
- ready never depends on a ready output.
REQ-009 ext_mem_read_en and ext_mem_write_en SHALL equal "a grant exists" on their port.
- Address and data outputs SHALL be muxed from the granted client.
- Address and data outputs SHALL be 0 when no grant exists.
REQ-010 Read/write address hazard: when the read candidate and the write candidate target the same address in the same cycle, the write SHALL be granted and the read SHALL be withheld.
- rd_ready = 0 and ext_mem_read_en = 0 in that cycle.
- The read pointer is not updated.
REQ-011 Read response timing: one cycle after a read grant to client i, rd_rsp_valid[i] SHALL be 1 and rd_rsp_data SHALL equal ext_mem_qout.
- Otherwise rd_rsp_valid = 0.
- rd_rsp_data passes ext_mem_qout through combinationally.
- The client identity SHALL be held in a 1-cycle registered tag.
REQ-012 Back-to-back reads to alternating clients SHALL sustain 1 grant per cycle with no bubble. Read and write throughput SHALL each be 1 word per cycle.
REQ-013 rd_count SHALL increment by 1 per accepted read and wr_count by 1 per accepted write.
- Counters saturate at 2^CNT_WIDTH-1 (no wrap).
REQ-014 When clear_counts = 1, both counters SHALL become 0 on the next edge. clear_counts has priority over a same-cycle increment, which is lost.
REQ-015 Write data SHALL not be buffered. A write that is not granted is held by its client, since valid must stay stable until ready.

Reset
REQ-016 On arst_n_in = 0, the following SHALL clear immediately, independent of clk:
- both pointers to 0;
- the read tag;
- rd_rsp_valid to 2'b00;
- rd_count and wr_count to 0.
REQ-017 A read granted in the cycle before reset asserts SHALL produce no response after reset. With all valids low during reset, every output SHALL be 0.
REQ-018 Reset release SHALL take effect on the first rising clk edge after arst_n_in goes high.

Verification
REQ-019 Both read clients continuously valid, addresses 0x10 and 0x20, after reset -> grants alternate 0,1,0,1 from cycle 0.
- rd_rsp_valid follows one cycle later.
- rd_rsp_data equals the memory contents at each address.
REQ-020 rd_valid = 2'b01 for 3 cycles, then 2'b11 -> client 0 is granted 3 times (pointer moves to 1 after each), then client 1 is granted first.
REQ-021 wr0 writes 0xDEADBEEF to 0x05 while rd1 reads 0x05 in the same cycle -> write granted, read withheld.
- The read is granted the next cycle.
- The response one cycle later is 0xDEADBEEF.
REQ-022 CNT_WIDTH = 4, 20 accepted writes -> wr_count saturates at 15.
- clear_counts asserted together with a write -> wr_count = 0 next cycle.
REQ-023 Assert arst_n_in mid-cycle, directly after a read grant -> rd_rsp_valid = 0 immediately, pointers 0, and counters 0.
- After release, the first grant goes to client 0 when both are valid.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: two-client round-robin arbitration of a single-port-read,
// single-port-write external memory. The read and write ports are arbitrated
// independently. A same-address read/write pair in one cycle gives the write
// precedence. Saturating counters track accepted reads and writes.
module ext_mem_arbiter #(
    parameter  int EXT_MEM_HEIGHT = 256,
    parameter  int EXT_MEM_WIDTH  = 32,
    parameter  int CNT_WIDTH      = 32,
    localparam int AW             = $clog2(EXT_MEM_HEIGHT),
    localparam int DW             = EXT_MEM_WIDTH
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic [1:0]           rd_valid,
    input  logic [AW-1:0]        rd0_addr,
    input  logic [AW-1:0]        rd1_addr,
    output logic [1:0]           rd_ready,
    output logic [1:0]           rd_rsp_valid,
    output logic [DW-1:0]        rd_rsp_data,
    input  logic [1:0]           wr_valid,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [DW-1:0]        wr0_data,
    input  logic [DW-1:0]        wr1_data,
    output logic [1:0]           wr_ready,
    output logic [AW-1:0]        ext_mem_read_addr,
    output logic                 ext_mem_read_en,
    input  logic [DW-1:0]        ext_mem_qout,
    output logic [AW-1:0]        ext_mem_write_addr,
    output logic [DW-1:0]        ext_mem_din,
    output logic                 ext_mem_write_en,
    input  logic                 clear_counts,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic          rd_ptr;       // preferred read client when both request
    logic          wr_ptr;       // preferred write client when both request
    logic [1:0]    rsp_tag;      // one-hot client owed read data this cycle

    logic          rd_cand;
    logic          rd_sel;
    logic          rd_grant;
    logic          hazard;
    logic          wr_grant;
    logic          wr_sel;
    logic [AW-1:0] rd_addr_sel;
    logic [AW-1:0] wr_addr_sel;
    logic [DW-1:0] wr_data_sel;

    // Pick a candidate per port, then withhold the read on an address clash.
    // NOTE: every signal gets a value on every path so no latch is inferred.
    always_comb begin
        wr_grant    = |wr_valid;
        wr_sel      = (&wr_valid) ? wr_ptr : wr_valid[1];
        wr_addr_sel = wr_sel ? wr1_addr : wr0_addr;
        wr_data_sel = wr_sel ? wr1_data : wr0_data;
        rd_cand     = |rd_valid;
        rd_sel      = (&rd_valid) ? rd_ptr : rd_valid[1];
        rd_addr_sel = rd_sel ? rd1_addr : rd0_addr;
        hazard      = rd_cand && wr_grant && (rd_addr_sel == wr_addr_sel);
        rd_grant    = rd_cand && !hazard;
    end

    // Drive grants and memory strobes; address/data are zero with no grant.
    always_comb begin
        rd_ready           = 2'b00;
        wr_ready           = 2'b00;
        rd_ready[rd_sel]   = rd_grant;
        wr_ready[wr_sel]   = wr_grant;
        ext_mem_read_en    = rd_grant;
        ext_mem_write_en   = wr_grant;
        ext_mem_read_addr  = rd_grant ? rd_addr_sel : '0;
        ext_mem_write_addr = wr_grant ? wr_addr_sel : '0;
        ext_mem_din        = wr_grant ? wr_data_sel : '0;
        rd_rsp_valid       = rsp_tag;
        rd_rsp_data        = (|rsp_tag) ? ext_mem_qout : '0;
    end

    // Round-robin pointers flip away from the winner; the tag remembers who read.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            rsp_tag <= 2'b00;
        end else begin
            if (rd_grant) rd_ptr <= ~rd_sel;
            if (wr_grant) wr_ptr <= ~wr_sel;
            rsp_tag <= rd_ready;
        end
    end

    // Saturating accepted-transfer counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (clear_counts) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_grant && rd_count != CNT_MAX) rd_count <= rd_count + CNT_WIDTH'(1);
            if (wr_grant && wr_count != CNT_MAX) wr_count <= wr_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed and randomized bench for ext_mem_arbiter with a
// behavioural memory and a transaction-level reference model.
module tb_ext_mem_arbiter;

    localparam int HEIGHT = 256;
    localparam int DW     = 32;
    localparam int CW     = 4;
    localparam int AW     = 8;
    localparam int CMAX   = 15;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic [1:0]    rd_valid, rd_ready, rd_rsp_valid;
    logic [AW-1:0] rd0_addr, rd1_addr;
    logic [DW-1:0] rd_rsp_data;
    logic [1:0]    wr_valid, wr_ready;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [AW-1:0] ext_mem_read_addr, ext_mem_write_addr;
    logic          ext_mem_read_en, ext_mem_write_en;
    logic [DW-1:0] ext_mem_qout = '0;
    logic [DW-1:0] ext_mem_din;
    logic          clear_counts;
    logic [CW-1:0] rd_count, wr_count;

    always #5 clk = ~clk;

    ext_mem_arbiter #(.EXT_MEM_HEIGHT(HEIGHT), .EXT_MEM_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .rd_valid(rd_valid), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd_ready(rd_ready), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_valid(wr_valid), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
        .wr0_data(wr0_data), .wr1_data(wr1_data), .wr_ready(wr_ready),
        .ext_mem_read_addr(ext_mem_read_addr), .ext_mem_read_en(ext_mem_read_en),
        .ext_mem_qout(ext_mem_qout), .ext_mem_write_addr(ext_mem_write_addr),
        .ext_mem_din(ext_mem_din), .ext_mem_write_en(ext_mem_write_en),
        .clear_counts(clear_counts), .rd_count(rd_count), .wr_count(wr_count)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    endfunction

    // Behavioural external memory: preloaded on the first edge, one-cycle read latency.
    logic [DW-1:0] mem [HEIGHT];
    bit            loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < HEIGHT; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else begin
            if (ext_mem_write_en) mem[ext_mem_write_addr] <= ext_mem_din;
            if (ext_mem_read_en)  ext_mem_qout <= mem[ext_mem_read_addr];
        end
    end

    // Reference model state
    int            rd_pref, wr_pref, ref_rd_cnt, ref_wr_cnt;
    logic [1:0]    exp_rsp;
    logic [DW-1:0] exp_rsp_data;
    logic [DW-1:0] ref_mem [HEIGHT];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner among the valid clients of one port, -1 when nobody asks.
    function automatic int pick(input logic [1:0] v, input int pref);
        if (v == 2'b11) return pref;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        rd_pref = 0; wr_pref = 0; ref_rd_cnt = 0; ref_wr_cnt = 0;
        exp_rsp = 2'b00; exp_rsp_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_ready"}, rd_ready, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rsp_valid"}, rd_rsp_valid, 0);
        check({tag, "_rsp_data"}, rd_rsp_data, 0);
        check({tag, "_rd_en"}, ext_mem_read_en, 0);
        check({tag, "_wr_en"}, ext_mem_write_en, 0);
        check({tag, "_rd_addr"}, ext_mem_read_addr, 0);
        check({tag, "_wr_addr"}, ext_mem_write_addr, 0);
        check({tag, "_din"}, ext_mem_din, 0);
        check({tag, "_rd_count"}, rd_count, 0);
        check({tag, "_wr_count"}, wr_count, 0);
    endtask

    // Compare one cycle against the model, then advance model and clock.
    task automatic step(input bit use_want = 1'b0, input logic [1:0] want = 2'b00);
        int            wc, rc;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        logic [1:0]    exp_rrdy, exp_wrdy, nxt_rsp;
        logic [DW-1:0] nxt_data;
        #1;
        wc = pick(wr_valid, wr_pref);
        rc = pick(rd_valid, rd_pref);
        wa = (wc == 1) ? wr1_addr : wr0_addr;
        wd = (wc == 1) ? wr1_data : wr0_data;
        ra = (rc == 1) ? rd1_addr : rd0_addr;
        if (rc >= 0 && wc >= 0 && ra == wa) rc = -1;
        exp_rrdy = 2'b00; exp_wrdy = 2'b00;
        if (rc >= 0) exp_rrdy[rc] = 1'b1;
        if (wc >= 0) exp_wrdy[wc] = 1'b1;
        if (use_want) check("rd_ready_directed", rd_ready, want);
        check("rd_ready", rd_ready, exp_rrdy);
        check("wr_ready", wr_ready, exp_wrdy);
        check("read_en", ext_mem_read_en, rc >= 0);
        check("write_en", ext_mem_write_en, wc >= 0);
        check("read_addr", ext_mem_read_addr, (rc >= 0) ? ra : '0);
        check("write_addr", ext_mem_write_addr, (wc >= 0) ? wa : '0);
        check("din", ext_mem_din, (wc >= 0) ? wd : '0);
        check("rsp_valid", rd_rsp_valid, exp_rsp);
        if (exp_rsp != 2'b00) check("rsp_data", rd_rsp_data, exp_rsp_data);
        check("rd_count", rd_count, ref_rd_cnt);
        check("wr_count", wr_count, ref_wr_cnt);
        nxt_rsp = 2'b00; nxt_data = '0;
        if (rc >= 0) begin
            nxt_rsp  = exp_rrdy;
            nxt_data = ref_mem[ra];
            rd_pref  = 1 - rc;
        end
        if (wc >= 0) begin
            ref_mem[wa] = wd;
            wr_pref     = 1 - wc;
        end
        if (clear_counts) begin
            ref_rd_cnt = 0; ref_wr_cnt = 0;
        end else begin
            if (rc >= 0 && ref_rd_cnt < CMAX) ref_rd_cnt++;
            if (wc >= 0 && ref_wr_cnt < CMAX) ref_wr_cnt++;
        end
        exp_rsp = nxt_rsp; exp_rsp_data = nxt_data;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < HEIGHT; i++) ref_mem[i] = init_word(i);
        arst_n_in = 1'b0; clear_counts = 1'b0;
        rd_valid = 2'b00; rd0_addr = '0; rd1_addr = '0;
        wr_valid = 2'b00; wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
        model_reset();

        // Outputs are all zero under reset with no requests.
        #12;
        check_all_zero("reset");
        #11 arst_n_in = 1'b1;
        @(posedge clk); #1;

        // Both readers always valid: grants alternate 0,1,0,1 with data one cycle later.
        rd_valid = 2'b11; rd0_addr = 8'h10; rd1_addr = 8'h20;
        for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);

        // Lone client 0 for three cycles, then both: client 1 wins first.
        rd_valid = 2'b01;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01);
        rd_valid = 2'b11;
        step(1'b1, 2'b10);

        // Same-address read/write: write wins, read follows and sees new data.
        rd_valid = 2'b10; rd1_addr = 8'h05;
        wr_valid = 2'b01; wr0_addr = 8'h05; wr0_data = 32'hDEAD_BEEF;
        step(1'b1, 2'b00);
        wr_valid = 2'b00;
        step(1'b1, 2'b10);
        rd_valid = 2'b00;
        #1;
        check("hazard_rsp_valid", rd_rsp_valid, 2'b10);
        check("hazard_rsp_data", rd_rsp_data, 32'hDEAD_BEEF);
        step();

        // Write counter saturation and clear-with-write.
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 2'($urandom_range(1, 3));
            wr0_addr = 8'($urandom_range(64, 127)); wr1_addr = 8'($urandom_range(128, 191));
            wr0_data = $urandom; wr1_data = $urandom;
            step();
        end
        wr_valid = 2'b00;
        #1 check("wr_count_saturated", wr_count, 4'd15);
        clear_counts = 1'b1; wr_valid = 2'b01;
        step();
        clear_counts = 1'b0; wr_valid = 2'b00;
        #1 check("wr_count_cleared", wr_count, 4'd0);
        step();

        // Randomized traffic over a narrow address range to provoke clashes.
        for (int i = 0; i < 300; i++) begin
            rd_valid = 2'($urandom_range(0, 3)); wr_valid = 2'($urandom_range(0, 3));
            rd0_addr = 8'($urandom_range(0, 7)); rd1_addr = 8'($urandom_range(0, 7));
            wr0_addr = 8'($urandom_range(0, 7)); wr1_addr = 8'($urandom_range(0, 7));
            wr0_data = $urandom; wr1_data = $urandom;
            clear_counts = ($urandom_range(0, 15) == 0);
            step();
        end
        clear_counts = 1'b0; wr_valid = 2'b00;

        // Reset right after a read grant to client 0 (pointer now 1).
        rd_valid = 2'b01; rd0_addr = 8'h33;
        step(1'b1, 2'b01);
        check("pre_reset_rsp_valid", rd_rsp_valid, 2'b01);
        #2 arst_n_in = 1'b0; rd_valid = 2'b00;
        model_reset();
        #1 check_all_zero("async_reset");
        @(posedge clk); @(posedge clk);
        #1 check_all_zero("held_reset");
        #1 arst_n_in = 1'b1; rd_valid = 2'b11; rd0_addr = 8'h40; rd1_addr = 8'h41;
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        rd_valid = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
